// File: rtl/rr_arbiter_4to2_if.sv
// Requester/arbiter bundle for the 4-way round-robin arbiter.
// Ports: req (requester -> arbiter); gnt, gnt_idx, gnt_vld, preempt, hold_cnt (arbiter -> requesters/encoder).
// master = requester side, slave = arbiter side.
interface rr_arbiter_4to2_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       gnt_idx;
  logic             gnt_vld;
  logic             preempt;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output req,
    input  gnt, gnt_idx, gnt_vld, preempt, hold_cnt
  );

  modport slave (
    input  req,
    output gnt, gnt_idx, gnt_vld, preempt, hold_cnt
  );
endinterface

// File: rtl/rr_arbiter_4to2.sv
// Round-robin arbiter sharing one 4-input encoder among four requesters; drives the encoder select.
// Latency: a request sampled at edge N is granted after edge N; every ownership change passes one idle cycle.
// Ports: clk, rst_n (sync, active-low); bus.req in; bus.gnt/gnt_idx/gnt_vld/preempt/hold_cnt out (all registered).
module rr_arbiter_4to2 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_arbiter_4to2_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [3:0]       gnt_q, gnt_nxt;
  logic [1:0]       idx_q, idx_nxt;
  logic             vld_q, vld_nxt;
  logic             pre_q, pre_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  logic [1:0]       win;
  logic             win_found;
  logic             others_waiting;

  // First requester at or after ptr, wrapping modulo 4 via 2-bit addition.
  always_comb begin
    win       = 2'd0;
    win_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && bus.req[ptr + 2'(k)]) begin
        win       = ptr + 2'(k);
        win_found = 1'b1;
      end
    end
  end

  // gnt_q is one-hot of the owner while in GRANT, so this masks the owner out.
  assign others_waiting = |(bus.req & ~gnt_q);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = 4'b0000;
    idx_nxt   = 2'd0;
    vld_nxt   = 1'b0;
    pre_nxt   = 1'b0;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << win;
          idx_nxt   = win;
          vld_nxt   = 1'b1;
        end
      end
      GRANT: begin
        if (!bus.req[idx_q]) begin
          // Release has priority over preemption when both apply.
          state_nxt = IDLE;
          ptr_nxt   = idx_q + 2'd1;
        end else if (cnt_q == CNT_LAST && others_waiting) begin
          state_nxt = IDLE;
          ptr_nxt   = idx_q + 2'd1;
          pre_nxt   = 1'b1;
        end else begin
          gnt_nxt = gnt_q;
          idx_nxt = idx_q;
          vld_nxt = 1'b1;
          cnt_nxt = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      gnt_q <= 4'b0000;
      idx_q <= 2'd0;
      vld_q <= 1'b0;
      pre_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt_q <= gnt_nxt;
      idx_q <= idx_nxt;
      vld_q <= vld_nxt;
      pre_q <= pre_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_idx  = idx_q;
  assign bus.gnt_vld  = vld_q;
  assign bus.preempt  = pre_q;
  assign bus.hold_cnt = cnt_q;

endmodule

// File: tb/tb_rr_arbiter_4to2.sv
// Self-checking bench for rr_arbiter_4to2: directed scenarios plus random requests vs a reference model.
// Outputs are sampled 1 time unit after each rising edge; inputs change at that point too.
// The model tracks owner/pointer/hold count as integers and applies the arbitration rules directly.
module tb_rr_arbiter_4to2;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 8;
  localparam int VW       = 8 + CNT_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_arbiter_4to2_if #(.CNT_W(CNT_W)) bus_if ();

  rr_arbiter_4to2 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: owner -1 means nobody holds the resource.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_pre   = 1'b0;

  task automatic model_edge();
    logic [3:0] r;
    r = bus_if.req;
    m_pre = 1'b0;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_cnt   = 0;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % 4; m_owner = -1; m_cnt = 0;
    end else if (m_cnt == MAX_HOLD - 1 && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
      m_ptr = (m_owner + 1) % 4; m_owner = -1; m_cnt = 0; m_pre = 1'b1;
    end else if (m_cnt < MAX_HOLD - 1) begin
      m_cnt = m_cnt + 1;
    end
  endtask

  function automatic logic [VW-1:0] expected();
    logic [3:0] g;
    logic [1:0] ix;
    logic       v;
    g  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    ix = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    v  = (m_owner >= 0);
    return {g, ix, v, m_pre, CNT_W'(m_cnt)};
  endfunction

  function automatic logic [VW-1:0] observed();
    return {bus_if.gnt, bus_if.gnt_idx, bus_if.gnt_vld, bus_if.preempt, bus_if.hold_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (observed() !== {VW{1'b0}}) begin
        errors++;
        $display("FAIL reset_hold c%0d: got %h, want 0", c, observed());
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus_if.gnt !== 4'b0001 || bus_if.gnt_idx !== 2'd0 || observed() !== expected()) begin
      errors++;
      $display("FAIL reset_release: got %h, want %h", observed(), expected());
    end
  endtask

  task automatic test_rotation();
    int   order[$];
    logic prev_vld;
    int   want[5];
    want = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; bus_if.req = 4'b1111;
    tick();
    rst_n = 1'b1;
    prev_vld = 1'b0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL rotation_cycle c%0d: got %h, want %h", c, observed(), expected());
      end
      if (bus_if.gnt_vld && !prev_vld) order.push_back(int'(bus_if.gnt_idx));
      prev_vld = bus_if.gnt_vld;
      // Owner drops its request for one cycle after two cycles of grant.
      bus_if.req = (m_owner >= 0 && m_cnt == 1) ? (4'b1111 & ~(4'b0001 << m_owner)) : 4'b1111;
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL rotation_count: got %0d grants, want 5", order.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order[i] != want[i]) begin
          errors++;
          $display("FAIL rotation_order[%0d]: got %0d, want %0d", i, order[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_hold_limit();
    int   owners[$];
    int   lens[$];
    int   cur_len;
    int   pre_cnt;
    logic prev_vld;
    rst_n = 1'b0; bus_if.req = 4'b0101;
    tick();
    rst_n = 1'b1;
    prev_vld = 1'b0; cur_len = 0; pre_cnt = 0;
    for (int c = 0; c < 19; c++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL hold_limit_cycle c%0d: got %h, want %h", c, observed(), expected());
      end
      if (bus_if.gnt_vld && !prev_vld) owners.push_back(int'(bus_if.gnt_idx));
      if (bus_if.gnt_vld) cur_len++;
      else if (prev_vld) begin lens.push_back(cur_len); cur_len = 0; end
      if (bus_if.preempt) pre_cnt++;
      prev_vld = bus_if.gnt_vld;
    end
    checks++;
    if (pre_cnt != 2) begin
      errors++;
      $display("FAIL hold_limit_preempts: got %0d, want 2", pre_cnt);
    end
    checks++;
    if (owners.size() != 3 || owners[0] != 0 || owners[1] != 2 || owners[2] != 0) begin
      errors++;
      $display("FAIL hold_limit_owners: got %0d grants, want order 0,2,0", owners.size());
    end
    checks++;
    if (lens.size() != 2 || lens[0] != 8 || lens[1] != 8) begin
      errors++;
      $display("FAIL hold_limit_lengths: got %0d completed grants, want two of 8 cycles", lens.size());
    end
  endtask

  task automatic test_lone();
    int bad;
    rst_n = 1'b0; bus_if.req = 4'b1000;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL lone_cycle c%0d: got %h, want %h", c, observed(), expected());
      end
      if (bus_if.gnt !== 4'b1000 || bus_if.gnt_idx !== 2'd3 || bus_if.preempt !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL lone_steady: got %0d bad cycles, want 0", bad);
    end
    checks++;
    if (bus_if.hold_cnt !== CNT_W'(MAX_HOLD - 1)) begin
      errors++;
      $display("FAIL lone_saturate: got %0d, want %0d", bus_if.hold_cnt, MAX_HOLD - 1);
    end
  endtask

  task automatic test_simultaneous();
    rst_n = 1'b0; bus_if.req = 4'b0011;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (bus_if.gnt !== 4'b0001 || bus_if.hold_cnt !== CNT_W'(7)) begin
      errors++;
      $display("FAIL simul_setup: got gnt=%b cnt=%0d, want 0001 cnt=7", bus_if.gnt, bus_if.hold_cnt);
    end
    // Owner drops on the same edge the hold limit would fire: release, not preempt.
    bus_if.req = 4'b1010;
    tick();
    checks++;
    if (bus_if.gnt !== 4'b0000 || bus_if.preempt !== 1'b0 || observed() !== expected()) begin
      errors++;
      $display("FAIL simul_release: got %h, want %h", observed(), expected());
    end
    tick();
    checks++;
    if (bus_if.gnt !== 4'b0010 || observed() !== expected()) begin
      errors++;
      $display("FAIL simul_next_owner: got gnt=%b, want 0010", bus_if.gnt);
    end
  endtask

  task automatic test_reset_mid_grant();
    rst_n = 1'b0; bus_if.req = 4'b0100;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (bus_if.gnt !== 4'b0100 || bus_if.hold_cnt !== CNT_W'(4)) begin
      errors++;
      $display("FAIL midrst_setup: got gnt=%b cnt=%0d, want 0100 cnt=4", bus_if.gnt, bus_if.hold_cnt);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (observed() !== {VW{1'b0}}) begin
      errors++;
      $display("FAIL midrst_clear: got %h, want 0", observed());
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus_if.gnt !== 4'b0100 || bus_if.gnt_idx !== 2'd2 || bus_if.hold_cnt !== '0) begin
      errors++;
      $display("FAIL midrst_regrant: got %h, want gnt=0100 idx=2 cnt=0", observed());
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    rst_n = 1'b0; bus_if.req = 4'b0000;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      r = bus_if.req;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      bus_if.req = r;
      rst_n = ($urandom_range(0, 59) != 0);
      tick();
      checks++;
      if (observed() !== expected()) begin
        errors++;
        $display("FAIL random_cycle c%0d req=%b: got %h, want %h", c, r, observed(), expected());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.req = 4'b0000;
    test_reset();
    test_rotation();
    test_hold_limit();
    test_lone();
    test_simultaneous();
    test_reset_mid_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
